// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder for the core's data port, backed by a word RAM.
// Latency: LATENCY cycles from request acceptance to rsp_valid; one request in flight at a time.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
//
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   req_valid/ready  request handshake; req_we, req_funct3, req_addr, req_wdata
//   rsp_valid/ready  response handshake; rsp_rdata (extended load data), rsp_err
module data_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH];

    logic          w_f3_ok;
    logic          w_misalign;
    logic          w_oor;
    logic          w_err;
    logic          w_fire;
    logic          w_wr;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [31:0]   w_wdat;
    logic [31:0]   w_rword;
    logic [31:0]   w_shift;
    logic [31:0]   w_rdata;

    assign req_ready = (r_state == S_IDLE) & rst;

    // Access happens on the last BUSY cycle; reset at that same edge drops it.
    assign w_fire = rst & (r_state == S_BUSY) & (r_cnt == 4'd0);
    assign w_wr   = w_fire & r_we & ~w_err;
    assign w_idx  = r_addr[2 +: AW];

    always_comb begin
        // funct3[1:0] encodes size (00 byte, 01 half, 10 word); funct3[2] is unsigned-load.
        if (r_we)
            w_f3_ok = (r_funct3 == 3'b000) | (r_funct3 == 3'b001) | (r_funct3 == 3'b010);
        else
            w_f3_ok = (r_funct3 == 3'b000) | (r_funct3 == 3'b001) | (r_funct3 == 3'b010) |
                      (r_funct3 == 3'b100) | (r_funct3 == 3'b101);
        w_misalign = ((r_funct3[1:0] == 2'b01) & r_addr[0]) |
                     ((r_funct3[1:0] == 2'b10) & (r_addr[1:0] != 2'b00));
        w_oor      = {2'b00, r_addr[31:2]} >= DEPTH_U;
        w_err      = ~w_f3_ok | w_misalign | w_oor;
    end

    // Store lane enables; data is replicated so each lane sees its own copy.
    always_comb begin
        w_be   = 4'b0000;
        w_wdat = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_be   = 4'b0001 << r_addr[1:0];
                w_wdat = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be   = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdat = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be   = 4'b1111;
                w_wdat = r_wdata;
            end
            default: w_be = 4'b0000;
        endcase
    end

    // Load path: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        w_rword = r_mem[w_idx];
        w_shift = w_rword >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'b000:  w_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b010:  w_rdata = w_rword;
            3'b100:  w_rdata = {24'd0, w_shift[7:0]};
            3'b101:  w_rdata = {16'd0, w_shift[15:0]};
            default: w_rdata = 32'd0;
        endcase
        if (r_we || w_err)
            w_rdata = 32'd0;
    end

    // RAM is never reset; previously committed data survives a core reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_cnt    <= CNT_INIT;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= w_rdata;
                        rsp_err   <= w_err;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: directed load/store vectors with a response scoreboard.
// Latency: checks rsp_valid rises exactly LATENCY cycles after each acceptance.
// Backpressure: holds rsp_ready low for a stretch and checks the response stays stable.
module tb_data_mem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   t_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    logic        valid_prev = 1'b0;
    logic        hs_prev    = 1'b0;
    logic [31:0] hold_rdata;
    logic        hold_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each new response and polices the handshake.
    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (!rst) begin
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            valid_prev = 1'b0;
            hs_prev    = 1'b0;
        end else begin
            if (hs_prev) begin
                chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
                chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            end
            hs_prev = 1'b0;
            if (rsp_valid) begin
                if (!valid_prev) begin
                    if (exp_q.size() == 0 || t_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
                    end else begin
                        e = exp_q.pop_front();
                        t = t_q.pop_front();
                        chk("latency", 32'(cyc), 32'(t));
                        chk("rdata", rsp_rdata, e.rdata);
                        chk("err", {31'd0, rsp_err}, {31'd0, e.err});
                    end
                    hold_rdata = rsp_rdata;
                    hold_err   = rsp_err;
                end else begin
                    chk("stable_rdata", rsp_rdata, hold_rdata);
                    chk("stable_err", {31'd0, rsp_err}, {31'd0, hold_err});
                    chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
                end
                if (rsp_ready)
                    hs_prev = 1'b1;
            end
            valid_prev = rsp_valid;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] er, input logic ee,
                         input bit expect_rsp);
        int n = 0;
        @(negedge clk); #1;
        while (!req_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL req_ready_timeout: got req_ready 0 for addr 0x%08h, expected 1", a);
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        if (expect_rsp)
            exp_q.push_back('{er, ee});
        @(posedge clk); #1;
        if (expect_rsp)
            t_q.push_back(cyc + LATENCY);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || rsp_valid) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int n;
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", {31'd0, req_ready}, 32'd1);

        //    we    f3      addr          wdata         exp rdata     err
        issue(1'b1, 3'b010, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'h20,       32'h11223344, 32'h0,        1'b0, 1'b1);
        issue(1'b1, 3'b000, 32'h23,       32'h00000080, 32'h0,        1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h20,       32'h0,        32'h80223344, 1'b0, 1'b1);
        issue(1'b0, 3'b000, 32'h23,       32'h0,        32'hFFFFFF80, 1'b0, 1'b1);
        issue(1'b0, 3'b100, 32'h23,       32'h0,        32'h00000080, 1'b0, 1'b1);
        issue(1'b1, 3'b000, 32'h21,       32'hFFFFFFA5, 32'h0,        1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h20,       32'h0,        32'h8022A544, 1'b0, 1'b1);
        issue(1'b0, 3'b000, 32'h21,       32'h0,        32'hFFFFFFA5, 1'b0, 1'b1);
        issue(1'b0, 3'b100, 32'h20,       32'h0,        32'h00000044, 1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'h40,       32'h01234567, 32'h0,        1'b0, 1'b1);
        issue(1'b1, 3'b001, 32'h42,       32'h0000F00D, 32'h0,        1'b0, 1'b1);
        issue(1'b0, 3'b001, 32'h42,       32'h0,        32'hFFFFF00D, 1'b0, 1'b1);
        issue(1'b0, 3'b101, 32'h42,       32'h0,        32'h0000F00D, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'h40,       32'h0,        32'hF00D4567, 1'b0, 1'b1);
        issue(1'b0, 3'b001, 32'h40,       32'h0,        32'h00004567, 1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'h04,       32'hCAFEF00D, 32'h0,        1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'h06,       32'h12345678, 32'h0,        1'b1, 1'b1);
        issue(1'b0, 3'b010, 32'h04,       32'h0,        32'hCAFEF00D, 1'b0, 1'b1);
        issue(1'b0, 3'b001, 32'h41,       32'h0,        32'h0,        1'b1, 1'b1);
        issue(1'b0, 3'b010, 32'h22,       32'h0,        32'h0,        1'b1, 1'b1);
        issue(1'b0, 3'b011, 32'h20,       32'h0,        32'h0,        1'b1, 1'b1);
        issue(1'b1, 3'b100, 32'h10,       32'h0,        32'h0,        1'b1, 1'b1);
        issue(1'b0, 3'b010, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0, 1'b1);
        issue(1'b1, 3'b010, 32'hFFC,      32'h0BADCAFE, 32'h0,        1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'hFFC,      32'h0,        32'h0BADCAFE, 1'b0, 1'b1);
        drain();

        // Backpressure: response must stay put for 5 cycles with rsp_ready low.
        rsp_ready = 1'b0;
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        repeat (4) @(negedge clk);
        #1 rsp_ready = 1'b1;
        drain();

        // Reset one cycle after accepting a store: the store must never commit.
        issue(1'b1, 3'b010, 32'h80, 32'h55555555, 32'h0, 1'b0, 1'b1);
        drain();
        issue(1'b1, 3'b010, 32'h80, 32'hAAAAAAAA, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        issue(1'b0, 3'b010, 32'h80, 32'h0, 32'h55555555, 1'b0, 1'b1);
        issue(1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 32'h0, 1'b1, 1'b1);
        drain();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
